emesh_packet_fifo: RTL

//  Show-ahead packet buffer that sits directly upstream of the emesh packet decoder.

---
 rtl/emesh_pkg.sv | 11 +
 rtl/emesh_fifo_ram.sv | 18 +
 rtl/emesh_packet_fifo.sv | 54 +++++
 3 files changed

// File: rtl/emesh_pkg.sv
// emesh_pkg: shared emesh packet width, field positions and datamode encoding
package emesh_pkg;
  localparam int PW = 104;
  localparam int WRITE_BIT = 0;
  localparam int DMODE_LSB = 1;
  localparam int CMODE_LSB = 3;
  localparam int DST_LSB = 8;
  localparam int DATA_LSB = 40;
  localparam int SRC_LSB = 72;
  typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} datamode_e;
endpackage

// File: rtl/emesh_fifo_ram.sv
// emesh_fifo_ram: DEPTH x PW register array, one write port, one async read port
module emesh_fifo_ram #(
  parameter int PW = 104,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [PW-1:0] rdata
);
  logic [PW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/emesh_packet_fifo.sv
// emesh_packet_fifo: show-ahead packet buffer with access/wait flow control,
// occupancy, pending-read count and sticky drop error
module emesh_packet_fifo #(
  parameter int PW = emesh_pkg::PW,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          access_in,
  input  logic [PW-1:0] packet_in,
  output logic          wait_out,
  output logic          access_out,
  output logic [PW-1:0] packet_out,
  input  logic          wait_in,
  output logic [CW-1:0] fifo_count,
  output logic [CW-1:0] rd_pending,
  output logic          drop_err
);
  import emesh_pkg::*;
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop, push_rd, pop_rd;
  assign full = fifo_count == CW'(DEPTH);
  assign empty = fifo_count == '0;
  assign wait_out = full;
  assign access_out = ~empty;
  assign push = access_in & ~full;
  assign pop = access_out & ~wait_in;
  assign push_rd = push & ~packet_in[WRITE_BIT];
  assign pop_rd = pop & ~packet_out[WRITE_BIT];
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      rd_pending <= '0;
      drop_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      rd_pending <= rd_pending + CW'(push_rd) - CW'(pop_rd);
      drop_err <= drop_err | (access_in & full);
    end
  emesh_fifo_ram #(.PW(PW), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(packet_in),
    .raddr(rd_ptr),
    .rdata(packet_out)
  );
endmodule
